// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Purpose  : Shared types and constants for the game controller blocks.
//             Provides the bludger penalty FSM state type, the player
//             channel indices and a saturating tally helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Per-player penalty sequence: idle -> stunned -> blinking immunity -> idle
    typedef enum logic [1:0] {
        P_IDLE   = 2'd0,
        P_STUN   = 2'd1,
        P_IMMUNE = 2'd2
    } penalty_state_t;

    // Player channel indices used to pack the four players into vectors
    localparam int CH_BLUE_VER = 0;
    localparam int CH_BLUE_HOR = 1;
    localparam int CH_RED_VER  = 2;
    localparam int CH_RED_HOR  = 3;
    localparam int NUM_CH      = 4;

    // Largest value a 4-bit team tally may reach
    localparam logic [3:0] HITS_MAX = 4'd15;

    // Add 0..2 new hits to a tally and clamp at HITS_MAX; never wraps.
    function automatic logic [3:0] sat_add_hits(input logic [3:0] tally,
                                                input logic [1:0] inc);
        logic [4:0] sum;
        sum = {1'b0, tally} + {3'b000, inc};
        if (sum > {1'b0, HITS_MAX}) begin
            return HITS_MAX;
        end
        return sum[3:0];
    endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/bludge_penalty_channel.sv
`default_nettype none
// ============================================================================
//  Module   : bludge_penalty_channel
//  Purpose  : Penalty sequencer for one player. Acknowledges every sampled
//             bludger hit with a one-cycle clean pulse, freezes the player
//             for STUN_CYCLES, then blinks it for IMMUNE_CYCLES of immunity.
//  Ports    :
//    clk            in   system clock
//    rst            in   synchronous reset, active-high
//    game_initiated in   1 = match running (hits only count while high)
//    bludged        in   hit flag, held high by the bludger until cleaned
//    clean          out  registered acknowledge pulse for each sampled hit
//    frozen         out  registered movement inhibit (high during stun)
//    visible        out  registered render enable (blinks during immunity)
//    hit_accepted   out  combinational strobe: this cycle's hit starts a stun
//  Revision : 1.0 - initial release
// ============================================================================
module bludge_penalty_channel
    import game_pkg::*;
#(
    parameter int STUN_CYCLES   = 50_000_000,
    parameter int IMMUNE_CYCLES = 25_000_000,
    parameter int BLINK_PERIOD  = 6_250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic game_initiated,
    input  logic bludged,
    output logic clean,
    output logic frozen,
    output logic visible,
    output logic hit_accepted
);

    // One down-counter serves both the stun and the immunity phase, so it is
    // sized for the larger of the two loads.
    localparam int c_cnt_max = (STUN_CYCLES > IMMUNE_CYCLES) ? STUN_CYCLES : IMMUNE_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_blk_w   = $clog2(BLINK_PERIOD + 1);

    localparam logic [c_cnt_w-1:0] c_stun_load   = c_cnt_w'(STUN_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_immune_load = c_cnt_w'(IMMUNE_CYCLES - 1);
    localparam logic [c_blk_w-1:0] c_blink_last  = c_blk_w'(BLINK_PERIOD - 1);

    penalty_state_t     r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_blk_w-1:0] r_blink;
    logic               r_clean;
    logic               r_frozen;
    logic               r_visible;

    // A hit only starts a penalty from IDLE during a running match; the top
    // level registers this strobe into the tally on the same edge as the
    // state change, so tally and clean/frozen update together.
    logic w_accept;
    assign w_accept = (r_state == P_IDLE) && bludged && game_initiated;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= P_IDLE;
            r_cnt     <= '0;
            r_blink   <= '0;
            r_clean   <= 1'b0;
            r_frozen  <= 1'b0;
            r_visible <= 1'b1;
        end else begin
            // Every sampled hit is acknowledged, whatever the state; the
            // bludger holds the flag until it sees clean, so a flag still
            // high one cycle later simply produces another harmless pulse.
            r_clean <= bludged;

            case (r_state)
                P_IDLE: begin
                    r_frozen  <= 1'b0;
                    r_visible <= 1'b1;
                    if (w_accept) begin
                        r_state  <= P_STUN;
                        r_cnt    <= c_stun_load;
                        r_frozen <= 1'b1;
                    end
                end

                P_STUN: begin
                    if (r_cnt == '0) begin
                        r_state  <= P_IMMUNE;
                        r_cnt    <= c_immune_load;
                        r_blink  <= '0;
                        r_frozen <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                P_IMMUNE: begin
                    if (r_cnt == '0) begin
                        // Immunity over: always leave with the player shown
                        r_state   <= P_IDLE;
                        r_visible <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_blink == c_blink_last) begin
                            r_blink   <= '0;
                            r_visible <= ~r_visible;
                        end else begin
                            r_blink <= r_blink + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state   <= P_IDLE;
                    r_frozen  <= 1'b0;
                    r_visible <= 1'b1;
                end
            endcase
        end
    end

    assign clean        = r_clean;
    assign frozen       = r_frozen;
    assign visible      = r_visible;
    assign hit_accepted = w_accept;

endmodule : bludge_penalty_channel
`default_nettype wire

// File: rtl/bludge_penalty_controller.sv
`default_nettype none
// ============================================================================
//  Module   : bludge_penalty_controller
//  Purpose  : Responder side of the bludger hit handshake for the four
//             players. One penalty channel per player plus per-team
//             saturating hit tallies.
//  Ports    :
//    clk, rst                       clock, synchronous active-high reset
//    game_initiated                 1 = match running
//    {blue,red}_{ver,hor}_bludged   in  hit flags held until cleaned
//    {blue,red}_{ver,hor}_clean     out acknowledge pulses
//    {blue,red}_{ver,hor}_frozen    out movement inhibits
//    {blue,red}_{ver,hor}_visible   out render enables
//    blue_hits, red_hits            out 4-bit tallies, saturate at 15
//  Revision : 1.0 - initial release
// ============================================================================
module bludge_penalty_controller
    import game_pkg::*;
#(
    parameter int STUN_CYCLES   = 50_000_000,
    parameter int IMMUNE_CYCLES = 25_000_000,
    parameter int BLINK_PERIOD  = 6_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_initiated,
    input  logic       blue_ver_bludged,
    input  logic       blue_hor_bludged,
    input  logic       red_ver_bludged,
    input  logic       red_hor_bludged,
    output logic       blue_ver_clean,
    output logic       blue_hor_clean,
    output logic       red_ver_clean,
    output logic       red_hor_clean,
    output logic       blue_ver_frozen,
    output logic       blue_hor_frozen,
    output logic       red_ver_frozen,
    output logic       red_hor_frozen,
    output logic       blue_ver_visible,
    output logic       blue_hor_visible,
    output logic       red_ver_visible,
    output logic       red_hor_visible,
    output logic [3:0] blue_hits,
    output logic [3:0] red_hits
);

    logic [NUM_CH-1:0] w_bludged;
    logic [NUM_CH-1:0] w_clean;
    logic [NUM_CH-1:0] w_frozen;
    logic [NUM_CH-1:0] w_visible;
    logic [NUM_CH-1:0] w_accept;

    assign w_bludged[CH_BLUE_VER] = blue_ver_bludged;
    assign w_bludged[CH_BLUE_HOR] = blue_hor_bludged;
    assign w_bludged[CH_RED_VER]  = red_ver_bludged;
    assign w_bludged[CH_RED_HOR]  = red_hor_bludged;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            bludge_penalty_channel #(
                .STUN_CYCLES   (STUN_CYCLES),
                .IMMUNE_CYCLES (IMMUNE_CYCLES),
                .BLINK_PERIOD  (BLINK_PERIOD)
            ) u_channel (
                .clk            (clk),
                .rst            (rst),
                .game_initiated (game_initiated),
                .bludged        (w_bludged[i]),
                .clean          (w_clean[i]),
                .frozen         (w_frozen[i]),
                .visible        (w_visible[i]),
                .hit_accepted   (w_accept[i])
            );
        end
    endgenerate

    // Both players of a team can be hit on the same edge, so each tally
    // may grow by 0..2 per cycle before clamping.
    logic [1:0] w_blue_inc;
    logic [1:0] w_red_inc;
    assign w_blue_inc = {1'b0, w_accept[CH_BLUE_VER]} + {1'b0, w_accept[CH_BLUE_HOR]};
    assign w_red_inc  = {1'b0, w_accept[CH_RED_VER]}  + {1'b0, w_accept[CH_RED_HOR]};

    logic [3:0] r_blue_hits;
    logic [3:0] r_red_hits;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blue_hits <= 4'd0;
            r_red_hits  <= 4'd0;
        end else begin
            r_blue_hits <= sat_add_hits(r_blue_hits, w_blue_inc);
            r_red_hits  <= sat_add_hits(r_red_hits, w_red_inc);
        end
    end

    assign blue_ver_clean   = w_clean[CH_BLUE_VER];
    assign blue_hor_clean   = w_clean[CH_BLUE_HOR];
    assign red_ver_clean    = w_clean[CH_RED_VER];
    assign red_hor_clean    = w_clean[CH_RED_HOR];
    assign blue_ver_frozen  = w_frozen[CH_BLUE_VER];
    assign blue_hor_frozen  = w_frozen[CH_BLUE_HOR];
    assign red_ver_frozen   = w_frozen[CH_RED_VER];
    assign red_hor_frozen   = w_frozen[CH_RED_HOR];
    assign blue_ver_visible = w_visible[CH_BLUE_VER];
    assign blue_hor_visible = w_visible[CH_BLUE_HOR];
    assign red_ver_visible  = w_visible[CH_RED_VER];
    assign red_hor_visible  = w_visible[CH_RED_HOR];
    assign blue_hits        = r_blue_hits;
    assign red_hits         = r_red_hits;

endmodule : bludge_penalty_controller
`default_nettype wire

// File: tb/tb_bludge_penalty_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bludge_penalty_controller
//  Purpose  : Self-checking bench for bludge_penalty_controller with short
//             stun/immunity/blink periods. A timeline model tracks, per
//             player, the number of cycles since its penalty started.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bludge_penalty_controller;

    localparam int S  = 8;   // stun cycles
    localparam int I  = 4;   // immunity cycles
    localparam int BP = 2;   // blink period

    logic       clk = 1'b0;
    logic       rst;
    logic       game;
    logic [3:0] bl;          // 0 blue_ver, 1 blue_hor, 2 red_ver, 3 red_hor
    wire  [3:0] cl;
    wire  [3:0] fz;
    wire  [3:0] vs;
    wire  [3:0] blue_hits;
    wire  [3:0] red_hits;

    int errors = 0;
    int checks = 0;

    // Model: cycles since the penalty began, -1 when never hit
    int         m_since [4];
    int         m_blue;
    int         m_red;
    logic [3:0] m_clean;

    always #5 clk = ~clk;

    bludge_penalty_controller #(
        .STUN_CYCLES   (S),
        .IMMUNE_CYCLES (I),
        .BLINK_PERIOD  (BP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .game_initiated   (game),
        .blue_ver_bludged (bl[0]),
        .blue_hor_bludged (bl[1]),
        .red_ver_bludged  (bl[2]),
        .red_hor_bludged  (bl[3]),
        .blue_ver_clean   (cl[0]),
        .blue_hor_clean   (cl[1]),
        .red_ver_clean    (cl[2]),
        .red_hor_clean    (cl[3]),
        .blue_ver_frozen  (fz[0]),
        .blue_hor_frozen  (fz[1]),
        .red_ver_frozen   (fz[2]),
        .red_hor_frozen   (fz[3]),
        .blue_ver_visible (vs[0]),
        .blue_hor_visible (vs[1]),
        .red_ver_visible  (vs[2]),
        .red_hor_visible  (vs[3]),
        .blue_hits        (blue_hits),
        .red_hits         (red_hits)
    );

    function automatic bit busy(input int s);
        return (s >= 0) && (s < S + I);
    endfunction

    function automatic logic [3:0] m_frozen();
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = (m_since[c] >= 0) && (m_since[c] < S);
        return v;
    endfunction

    // Immunity cycle k shows the player when floor(k/BP) is even
    function automatic logic [3:0] m_visible();
        logic [3:0] v;
        for (int c = 0; c < 4; c++) begin
            if (m_since[c] >= S && m_since[c] < S + I)
                v[c] = (((m_since[c] - S) / BP) % 2) == 0;
            else
                v[c] = 1'b1;
        end
        return v;
    endfunction

    // Advance one clock edge, update the model from the inputs presented at
    // that edge, and return 1 time unit later for sampling.
    task automatic step();
        int acc_b, acc_r;
        @(posedge clk);
        if (rst) begin
            for (int c = 0; c < 4; c++) m_since[c] = -1;
            m_blue  = 0;
            m_red   = 0;
            m_clean = 4'b0;
        end else begin
            acc_b = 0;
            acc_r = 0;
            for (int c = 0; c < 4; c++) begin
                m_clean[c] = bl[c];
                if (busy(m_since[c])) begin
                    m_since[c]++;
                end else if (bl[c] && game) begin
                    m_since[c] = 0;
                    if (c < 2) acc_b++; else acc_r++;
                end
            end
            m_blue = (m_blue + acc_b > 15) ? 15 : m_blue + acc_b;
            m_red  = (m_red + acc_r > 15) ? 15 : m_red + acc_r;
        end
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        game = 1'b0;
        bl   = 4'b0;
        step();
        step();
        checks++; if (cl !== 4'b0000) begin errors++; $display("FAIL reset_clean got=%b want=0000", cl); end
        checks++; if (fz !== 4'b0000) begin errors++; $display("FAIL reset_frozen got=%b want=0000", fz); end
        checks++; if (vs !== 4'b1111) begin errors++; $display("FAIL reset_visible got=%b want=1111", vs); end
        checks++; if (blue_hits !== 4'd0 || red_hits !== 4'd0) begin
            errors++; $display("FAIL reset_hits got=%0d/%0d want=0/0", blue_hits, red_hits); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_hit();
        int         n_clean, n_frozen;
        logic [13:0] vis_seq;
        logic [13:0] vis_want;
        bit         seen;
        vis_want = 14'b11_00_11_11111111;  // bit i = visible in cycle i
        game  = 1'b1;
        bl[0] = 1'b1;
        seen  = 0;
        for (int t = 0; t < 5 && !seen; t++) begin
            step();
            if (cl[0] === 1'b1) seen = 1;
        end
        bl[0] = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL hit_clean_seen got=0 want=1"); end
        checks++; if (blue_hits !== 4'd1) begin errors++; $display("FAIL hit_tally got=%0d want=1", blue_hits); end
        n_clean  = 0;
        n_frozen = 0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) step();
            n_clean  += int'(cl[0]);
            n_frozen += int'(fz[0]);
            vis_seq[i] = vs[0];
        end
        checks++; if (n_clean != 1) begin errors++; $display("FAIL hit_clean_len got=%0d want=1", n_clean); end
        checks++; if (n_frozen != S) begin errors++; $display("FAIL hit_frozen_len got=%0d want=%0d", n_frozen, S); end
        checks++; if (vis_seq !== vis_want) begin errors++; $display("FAIL hit_blink got=%b want=%b", vis_seq, vis_want); end
    endtask

    task automatic test_rehit();
        int n_clean, n_frozen;
        bl[3] = 1'b1;
        step();
        bl[3] = 1'b0;
        n_clean  = int'(cl[3]);
        n_frozen = int'(fz[3]);
        for (int i = 1; i < 14; i++) begin
            bl[3] = (i == 4) || (i == 10);   // sampled during stun, then immunity
            step();
            n_clean  += int'(cl[3]);
            n_frozen += int'(fz[3]);
        end
        bl[3] = 1'b0;
        checks++; if (n_clean != 3) begin errors++; $display("FAIL rehit_clean got=%0d want=3", n_clean); end
        checks++; if (n_frozen != S) begin errors++; $display("FAIL rehit_frozen got=%0d want=%0d", n_frozen, S); end
        checks++; if (red_hits !== 4'd1) begin errors++; $display("FAIL rehit_tally got=%0d want=1", red_hits); end
    endtask

    task automatic blue_hit(input logic [1:0] mask);
        bl[1:0] = mask;
        step();
        bl[1:0] = 2'b00;
        for (int i = 0; i < S + I + 1; i++) step();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 6; k++) blue_hit(2'b11);   // 1 -> 13
        blue_hit(2'b01);                                 // 14
        checks++; if (blue_hits !== 4'd14) begin errors++; $display("FAIL sat_pre got=%0d want=14", blue_hits); end
        blue_hit(2'b11);
        checks++; if (blue_hits !== 4'd15) begin errors++; $display("FAIL sat_pair got=%0d want=15", blue_hits); end
        blue_hit(2'b10);
        checks++; if (blue_hits !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d want=15", blue_hits); end
    endtask

    task automatic test_no_game();
        game  = 1'b0;
        bl[2] = 1'b1;
        step();
        bl[2] = 1'b0;
        checks++; if (cl[2] !== 1'b1) begin errors++; $display("FAIL nogame_clean got=%b want=1", cl[2]); end
        checks++; if (fz[2] !== 1'b0) begin errors++; $display("FAIL nogame_frozen got=%b want=0", fz[2]); end
        step();
        checks++; if (fz[2] !== 1'b0 || cl[2] !== 1'b0) begin
            errors++; $display("FAIL nogame_after got=%b%b want=00", fz[2], cl[2]); end
        checks++; if (red_hits !== 4'd1) begin errors++; $display("FAIL nogame_tally got=%0d want=1", red_hits); end
        game = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n_frozen;
        bl[1] = 1'b1;
        step();
        bl[1] = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (fz[1] !== 1'b0 || vs[1] !== 1'b1) begin
            errors++; $display("FAIL rstmid_out got=f%b v%b want=f0 v1", fz[1], vs[1]); end
        checks++; if (blue_hits !== 4'd0 || red_hits !== 4'd0) begin
            errors++; $display("FAIL rstmid_hits got=%0d/%0d want=0/0", blue_hits, red_hits); end
        bl[1] = 1'b1;
        step();
        bl[1] = 1'b0;
        n_frozen = int'(fz[1]);
        for (int i = 1; i < 14; i++) begin
            step();
            n_frozen += int'(fz[1]);
        end
        checks++; if (n_frozen != S) begin errors++; $display("FAIL rstmid_restun got=%0d want=%0d", n_frozen, S); end
        checks++; if (blue_hits !== 4'd1) begin errors++; $display("FAIL rstmid_tally got=%0d want=1", blue_hits); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int n = 0; n < 3000; n++) begin
            game = ($urandom % 8) != 0;
            for (int c = 0; c < 4; c++) bl[c] = ($urandom % 6) == 0;
            rst  = ($urandom % 400) == 0;
            step();
            checks++; if (cl !== m_clean) begin errors++; bad++;
                if (bad < 10) $display("FAIL rand_clean cyc=%0d got=%b want=%b", n, cl, m_clean); end
            checks++; if (fz !== m_frozen()) begin errors++; bad++;
                if (bad < 10) $display("FAIL rand_frozen cyc=%0d got=%b want=%b", n, fz, m_frozen()); end
            checks++; if (vs !== m_visible()) begin errors++; bad++;
                if (bad < 10) $display("FAIL rand_visible cyc=%0d got=%b want=%b", n, vs, m_visible()); end
            checks++; if (int'(blue_hits) != m_blue || int'(red_hits) != m_red) begin errors++; bad++;
                if (bad < 10) $display("FAIL rand_hits cyc=%0d got=%0d/%0d want=%0d/%0d",
                                       n, blue_hits, red_hits, m_blue, m_red); end
        end
        rst = 1'b0;
        bl  = 4'b0;
    endtask

    initial begin
        for (int c = 0; c < 4; c++) m_since[c] = -1;
        m_blue  = 0;
        m_red   = 0;
        m_clean = 4'b0;
        test_reset();
        test_single_hit();
        test_rehit();
        test_saturation();
        test_no_game();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bludge_penalty_controller
`default_nettype wire
